// File: rtl/hazard_sequencer.sv
// Pipeline sequencer: RAW scoreboard stalls, redirect flush, stop drain/halt; HAZARD_BYPASS_EN enables WB write-through.
// Latency: controls are combinational from state, scoreboard and current ID/EX/WB inputs (zero cycle).
// Backpressure: a hazard holds PC and IF/ID and bubbles ID/EX; DRAIN and HALTED freeze the front end.
module hazard_sequencer #(
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_regwrite,
    input  logic            id_stop,
    input  logic            ex_redirect,
    input  logic            wb_regwrite,
    input  logic [AW-1:0]   wb_rd,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_bubble,
    output logic            flush,
    output logic            halted,
    output logic [NREG-1:0] sb_busy
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t          state;
    logic [2:0]      flush_cnt;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            hazard;
    logic            issue;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] sb_next;

`ifdef HAZARD_BYPASS_EN
    // Register file writes through, so a source retiring in WB this cycle is readable now.
    assign rs1_busy = sb_busy[id_rs1] & ~(wb_regwrite && (wb_rd == id_rs1));
    assign rs2_busy = sb_busy[id_rs2] & ~(wb_regwrite && (wb_rd == id_rs2));
`else
    assign rs1_busy = sb_busy[id_rs1];
    assign rs2_busy = sb_busy[id_rs2];
`endif

    assign hazard = id_valid & ((id_use_rs1 & rs1_busy) | (id_use_rs2 & rs2_busy));
    assign issue  = (state == ST_RUN) & id_valid & ~hazard & ~ex_redirect;

    // Set is applied after clear so a new writer wins over a retiring one; r0 is never tracked.
    assign clr_mask = wb_regwrite ? (NREG'(1) << wb_rd) : '0;
    assign set_mask = (issue && id_regwrite && (id_rd != '0)) ? (NREG'(1) << id_rd) : '0;
    assign sb_next  = (sb_busy & ~clr_mask) | set_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            sb_busy   <= '0;
        end else begin
            sb_busy <= sb_next;
            case (state)
                ST_RUN: begin
                    if (ex_redirect) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end else if (issue && id_stop) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_FLUSH: begin
                    if (ex_redirect) begin
                        flush_cnt <= FLUSH_LOAD;
                    end else if (flush_cnt <= 3'd1) begin
                        state     <= ST_RUN;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (ex_redirect) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end else if (sb_busy == '0) begin
                        state <= ST_HALTED;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        flush       = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_RUN: begin
                if (ex_redirect) begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    flush   = 1'b1;
                end else begin
                    pc_en       = ~hazard;
                    ifid_en     = ~hazard;
                    idex_bubble = hazard | ~id_valid;
                end
            end
            ST_FLUSH: begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                flush   = 1'b1;
            end
            ST_DRAIN: begin
                if (ex_redirect) begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    flush   = 1'b1;
                end
            end
            ST_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Table-driven bench for hazard_sequencer with an expectation queue and hand-written reset/redirect corner sequences.
module tb_hazard_sequencer;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       rw;
        logic       stop;
        logic       redir;
        logic       wbw;
        logic [4:0] wbrd;
    } in_t;

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        bub;
        logic        fl;
        logic        halt;
        logic [31:0] sb;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_stop;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        ex_redirect, wb_regwrite;
    logic        pc_en, ifid_en, idex_bubble, flush, halted;
    logic [31:0] sb_busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    hazard_sequencer #(.NREG(32), .AW(5), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_stop(id_stop),
        .ex_redirect(ex_redirect), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_bubble(idex_bubble),
        .flush(flush), .halted(halted), .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    function automatic in_t idle();
        in_t x = '0;
        return x;
    endfunction
    function automatic in_t wr(input logic [4:0] r);
        in_t x = '0;
        x.valid = 1'b1; x.rd = r; x.rw = 1'b1;
        return x;
    endfunction
    function automatic in_t rd12(input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub);
        in_t x = '0;
        x.valid = 1'b1; x.rs1 = a; x.use1 = ua; x.rs2 = b; x.use2 = ub;
        return x;
    endfunction
    function automatic in_t wb(input in_t x, input logic [4:0] r);
        in_t y = x;
        y.wbw = 1'b1; y.wbrd = r;
        return y;
    endfunction
    function automatic in_t redir(input in_t x);
        in_t y = x;
        y.redir = 1'b1;
        return y;
    endfunction
    function automatic in_t stp();
        in_t x = '0;
        x.valid = 1'b1; x.stop = 1'b1;
        return x;
    endfunction

    function automatic exp_t mk(input logic p, input logic f, input logic b, input logic fl, input logic h, input logic [31:0] s);
        exp_t e;
        e.pc = p; e.ifid = f; e.bub = b; e.fl = fl; e.halt = h; e.sb = s;
        return e;
    endfunction
    function automatic exp_t e_issue(input logic [31:0] s); return mk(1, 1, 0, 0, 0, s); endfunction
    function automatic exp_t e_idle (input logic [31:0] s); return mk(1, 1, 1, 0, 0, s); endfunction
    function automatic exp_t e_stall(input logic [31:0] s); return mk(0, 0, 1, 0, 0, s); endfunction
    function automatic exp_t e_flush(input logic [31:0] s); return mk(1, 1, 1, 1, 0, s); endfunction
    function automatic exp_t e_halt (input logic [31:0] s); return mk(0, 0, 1, 0, 1, s); endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.i = i; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t i);
        id_valid    = i.valid; id_rs1 = i.rs1; id_use_rs1 = i.use1;
        id_rs2      = i.rs2;   id_use_rs2 = i.use2;
        id_rd       = i.rd;    id_regwrite = i.rw; id_stop = i.stop;
        ex_redirect = i.redir; wb_regwrite = i.wbw; wb_rd = i.wbrd;
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
        end
    endtask

    task automatic compare(input string nm);
        exp_t x;
        if (exp_q.size() == 0) begin
            chk(nm, "queue_empty", 32'd1, 32'd0);
            return;
        end
        x = exp_q.pop_front();
        chk(nm, "pc_en",       {31'd0, pc_en},       {31'd0, x.pc});
        chk(nm, "ifid_en",     {31'd0, ifid_en},     {31'd0, x.ifid});
        chk(nm, "idex_bubble", {31'd0, idex_bubble}, {31'd0, x.bub});
        chk(nm, "flush",       {31'd0, flush},       {31'd0, x.fl});
        chk(nm, "halted",      {31'd0, halted},      {31'd0, x.halt});
        chk(nm, "sb_busy",     sb_busy,              x.sb);
    endtask

    // Drive one cycle of inputs, expect at the following falling edge, return just after the rising edge.
    task automatic step(input string nm, input in_t i, input exp_t e);
        drive(i);
        exp_q.push_back(e);
        @(negedge clk);
        compare(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(idle());
        #3;
        exp_q.push_back(e_idle(0));
        compare("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        add(idle(), e_idle(0));
        add(wr(5), e_issue(0));
        add(rd12(5, 1, 0, 0), e_stall(32'h20));
        add(rd12(5, 1, 0, 0), e_stall(32'h20));
`ifdef HAZARD_BYPASS_EN
        add(wb(rd12(5, 1, 0, 0), 5), e_issue(32'h20));
`else
        add(wb(rd12(5, 1, 0, 0), 5), e_stall(32'h20));
`endif
        add(rd12(5, 1, 0, 0), e_issue(0));
        add(wr(0), e_issue(0));
        add(rd12(0, 1, 0, 1), e_issue(0));
        add(wr(7), e_issue(0));
        add(rd12(7, 0, 7, 0), e_issue(32'h80));
        add(rd12(0, 1, 7, 1), e_stall(32'h80));
        add(redir(rd12(7, 1, 0, 0)), e_flush(32'h80));
        add(rd12(7, 1, 0, 0), e_flush(32'h80));
        add(wb(idle(), 7), e_idle(32'h80));
        add(wr(3), e_issue(0));
        add(wb(wr(3), 3), e_issue(32'h8));
        add(wb(idle(), 3), e_idle(32'h8));
        add(wr(2), e_issue(0));
        add(wr(9), e_issue(32'h4));
        add(stp(), e_issue(32'h204));
        add(wb(wr(11), 2), e_stall(32'h204));
        add(wb(idle(), 9), e_stall(32'h200));
        add(idle(), e_stall(0));
        add(redir(idle()), e_halt(0));
        add(wr(4), e_halt(0));
        add(idle(), e_halt(0));

        for (int k = 0; k < tbl.size(); k++)
            step($sformatf("tbl%0d", k), tbl[k].i, tbl[k].e);

        // Reset while draining with r4 pending.
        pulse_reset();
        step("rst_wr4", wr(4), e_issue(0));
        step("rst_stop", stp(), e_issue(32'h10));
        step("rst_drain", idle(), e_stall(32'h10));
        drive(idle());
        reset = 1'b1;
        #2;
        exp_q.push_back(e_idle(0));
        compare("rst_mid_drain");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step("rst_run", idle(), e_idle(0));

        // Redirect during FLUSH reloads the counter.
        step("rl_redir0", redir(idle()), e_flush(0));
        step("rl_redir1", redir(idle()), e_flush(0));
        step("rl_flush", idle(), e_flush(0));
        step("rl_run", idle(), e_idle(0));

        // Redirect during DRAIN takes priority over halting.
        step("dr_stop", stp(), e_issue(0));
        step("dr_redir", redir(idle()), e_flush(0));
        step("dr_flush", idle(), e_flush(0));
        step("dr_run", rd12(1, 1, 2, 1), e_issue(0));

        chk("end", "queue_left", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
